// File: rtl/arbitro_memoria.sv
// Shared single-port memory arbiter for the IF (fetch) and MEM (data) pipeline ports.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX data wins.
module arbitro_memoria #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam logic [2:0] LAT_INIT     = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic                gnt_data_q, gnt_data_d;
  logic                we_q, we_d;
  logic [2:0]          lat_cnt_q, lat_cnt_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                pick_data;

  always_comb begin
    state_d      = state_q;
    gnt_data_d   = gnt_data_q;
    we_d         = we_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    pick_data    = d_req & ~(i_req & (starve_cnt_q == STARVE_MAX_C));

    case (state_q)
      IDLE: begin
        // The strobe is registered here so it is visible during the STROBE cycle.
        if (i_req | d_req) begin
          gnt_data_d = pick_data;
          state_d    = STROBE;
          if (pick_data) begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            we_d        = d_we;
            mem_rd_d    = ~d_we;
            mem_wr_d    = d_we;
            if (i_req && (starve_cnt_q != STARVE_MAX_C)) begin
              starve_cnt_d = starve_cnt_q + 4'd1;
            end else begin
              starve_cnt_d = starve_cnt_q;
            end
          end else begin
            mem_addr_d   = i_addr;
            we_d         = 1'b0;
            mem_rd_d     = 1'b1;
            starve_cnt_d = 4'd0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      STROBE: begin
        lat_cnt_d = LAT_INIT;
        state_d   = WAIT;
      end
      WAIT: begin
        if (lat_cnt_q != 3'd0) begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end else begin
          if (!we_q) begin
            if (gnt_data_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              i_rdata_d = mem_rdata;
            end
          end else begin
            d_rdata_d = d_rdata_q;
          end
          d_ack_d = gnt_data_q;
          i_ack_d = ~gnt_data_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_data_q   <= 1'b0;
      we_q         <= 1'b0;
      lat_cnt_q    <= 3'd0;
      starve_cnt_q <= 4'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      gnt_data_q   <= gnt_data_d;
      we_q         <= we_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall_if  = i_req & ~i_ack_q;
  assign stall_mem = d_req & ~d_ack_q;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Scoreboard bench for arbitro_memoria: instance 0 uses MEM_LAT=1, instance 1 uses MEM_LAT=3.
module tb_arbitro_memoria;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        i_req [2], d_req [2], d_we [2], i_ack [2], d_ack [2];
  logic        mem_rd [2], mem_wr [2], stall_if [2], stall_mem [2];
  logic [31:0] i_addr [2], d_addr [2], d_wdata [2], i_rdata [2], d_rdata [2];
  logic [31:0] mem_addr [2], mem_wdata [2], mem_rdata [2];

  int          mcnt [2];
  logic [31:0] mdata [2];
  logic [31:0] mem_store [2][1024];
  bit          wr_valid [2][1024];

  logic [31:0] exp_i [$];
  logic [31:0] exp_d [$];
  logic [31:0] last_d [2];
  int tests_run = 0;
  int fails = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    arbitro_memoria #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT((g == 0) ? 1 : 3), .STARVE_MAX(4)
    ) u_dut (
      .clock(clock), .reset(reset),
      .i_req(i_req[g]), .i_addr(i_addr[g]), .i_rdata(i_rdata[g]), .i_ack(i_ack[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_rdata(d_rdata[g]), .d_ack(d_ack[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rd(mem_rd[g]), .mem_wr(mem_wr[g]),
      .mem_rdata(mem_rdata[g]), .stall_if(stall_if[g]), .stall_mem(stall_mem[g])
    );
    // Read data is valid only in the cycle MEM_LAT after the strobe; other cycles carry junk.
    assign mem_rdata[g] = (mcnt[g] == 1) ? mdata[g] : 32'hBAD0_BAD0;
  end

  function automatic logic [31:0] mem_val(int k, logic [31:0] a);
    if (wr_valid[k][a[11:2]]) return mem_store[k][a[11:2]];
    else if (a == 32'h0000_0040) return 32'h8C01_0004;
    else return a ^ 32'h5A00_0000 ^ ((k == 1) ? 32'h00F0_0000 : 32'h0000_0000);
  endfunction

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_rd[k]) begin
        mcnt[k]  <= (k == 0) ? 1 : 3;
        mdata[k] <= mem_val(k, mem_addr[k]);
      end else if (mcnt[k] != 0) begin
        mcnt[k] <= mcnt[k] - 1;
      end
      if (mem_wr[k]) begin
        mem_store[k][mem_addr[k][11:2]] <= mem_wdata[k];
        wr_valid[k][mem_addr[k][11:2]]  <= 1'b1;
      end
    end
  end

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        if (i_ack[k] === 1'b1) begin
          tests_run++;
          if (exp_i.size() == 0) begin
            fails++;
            $display("FAIL i_ack_unexpected inst=%0d ack seen, required none", k);
          end else begin
            e = exp_i.pop_front();
            if (i_rdata[k] !== e) begin
              fails++;
              $display("FAIL i_rdata inst=%0d got %h required %h", k, i_rdata[k], e);
            end
          end
        end
        if (d_ack[k] === 1'b1) begin
          tests_run++;
          if (exp_d.size() == 0) begin
            fails++;
            $display("FAIL d_ack_unexpected inst=%0d ack seen, required none", k);
          end else begin
            e = exp_d.pop_front();
            last_d[k] = e;
            if (d_rdata[k] !== e) begin
              fails++;
              $display("FAIL d_rdata inst=%0d got %h required %h", k, d_rdata[k], e);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      i_addr[k] = 32'h0; d_addr[k] = 32'h0; d_wdata[k] = 32'h0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if ({mem_rd[k], mem_wr[k], i_ack[k], d_ack[k], stall_if[k], stall_mem[k]} !== 6'b0) begin
        fails++;
        $display("FAIL reset_ctrl inst=%0d got %b required 000000", k,
                 {mem_rd[k], mem_wr[k], i_ack[k], d_ack[k], stall_if[k], stall_mem[k]});
      end
      tests_run++;
      if ((mem_addr[k] | mem_wdata[k] | i_rdata[k] | d_rdata[k]) !== 32'h0) begin
        fails++;
        $display("FAIL reset_data inst=%0d got addr=%h wdata=%h ird=%h drd=%h required 0",
                 k, mem_addr[k], mem_wdata[k], i_rdata[k], d_rdata[k]);
      end
      last_d[k] = 32'h0;
    end
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic test_lone_fetch();
    @(posedge clock); #1;
    i_req[0] = 1'b1; i_addr[0] = 32'h40;
    exp_i.push_back(32'h8C01_0004);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      tests_run++;
      if (mem_rd[0] !== (c == 1)) begin
        fails++; $display("FAIL lone_mem_rd c=%0d got %b required %b", c, mem_rd[0], (c == 1));
      end
      if (c == 1) begin
        tests_run++;
        if (mem_addr[0] !== 32'h40) begin
          fails++; $display("FAIL lone_mem_addr got %h required 00000040", mem_addr[0]);
        end
      end
      tests_run++;
      if (i_ack[0] !== (c == 3)) begin
        fails++; $display("FAIL lone_i_ack c=%0d got %b required %b", c, i_ack[0], (c == 3));
      end
      tests_run++;
      if (stall_if[0] !== (c <= 2)) begin
        fails++; $display("FAIL lone_stall_if c=%0d got %b required %b", c, stall_if[0], (c <= 2));
      end
      @(posedge clock); #1;
      if (c == 3) i_req[0] = 1'b0;
    end
  endtask

  task automatic test_starvation();
    int nd = 0;
    int i_pos = -1;
    logic ackd, acki;
    @(posedge clock); #1;
    i_req[0] = 1'b1; i_addr[0] = 32'h44;
    exp_i.push_back(mem_val(0, 32'h44));
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h300;
    exp_d.push_back(mem_val(0, 32'h300));
    for (int c = 0; c < 80 && !(nd == 5 && i_pos >= 0); c++) begin
      @(negedge clock);
      ackd = d_ack[0];
      acki = i_ack[0];
      @(posedge clock); #1;
      if (acki) begin
        i_pos = nd;
        i_req[0] = 1'b0;
      end
      if (ackd) begin
        nd++;
        if (nd < 5) begin
          d_addr[0] = 32'h300 + 32'(nd * 4);
          exp_d.push_back(mem_val(0, d_addr[0]));
        end else begin
          d_req[0] = 1'b0;
        end
      end
    end
    tests_run++;
    if (i_pos !== 4) begin
      fails++; $display("FAIL starve_fetch_position got %0d data acks before fetch required 4", i_pos);
    end
    tests_run++;
    if (nd !== 5) begin
      fails++; $display("FAIL starve_data_count got %0d required 5", nd);
    end
  endtask

  task automatic test_conflict();
    @(posedge clock); #1;
    i_req[0] = 1'b1; i_addr[0] = 32'h48;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h100;
    exp_d.push_back(mem_val(0, 32'h100));
    exp_i.push_back(mem_val(0, 32'h48));
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      tests_run++;
      if (mem_rd[0] !== (c == 1 || c == 5)) begin
        fails++; $display("FAIL conf_mem_rd c=%0d got %b required %b", c, mem_rd[0], (c == 1 || c == 5));
      end
      if (c == 1 || c == 5) begin
        tests_run++;
        if (mem_addr[0] !== ((c == 1) ? 32'h100 : 32'h48)) begin
          fails++; $display("FAIL conf_mem_addr c=%0d got %h", c, mem_addr[0]);
        end
      end
      tests_run++;
      if ({d_ack[0], i_ack[0]} !== {(c == 3), (c == 7)}) begin
        fails++; $display("FAIL conf_acks c=%0d got d=%b i=%b required d=%b i=%b",
                          c, d_ack[0], i_ack[0], (c == 3), (c == 7));
      end
      tests_run++;
      if ({stall_if[0], stall_mem[0]} !== {(c <= 6), (c <= 2)}) begin
        fails++; $display("FAIL conf_stalls c=%0d got if=%b mem=%b required if=%b mem=%b",
                          c, stall_if[0], stall_mem[0], (c <= 6), (c <= 2));
      end
      @(posedge clock); #1;
      if (c == 3) d_req[0] = 1'b0;
      if (c == 7) i_req[0] = 1'b0;
    end
  endtask

  task automatic test_write();
    bit seen = 1'b0;
    @(posedge clock); #1;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h200; d_wdata[0] = 32'hDEAD_BEEF;
    exp_d.push_back(last_d[0]);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      tests_run++;
      if ({mem_wr[0], mem_rd[0], d_ack[0]} !== {(c == 1), 1'b0, (c == 3)}) begin
        fails++; $display("FAIL wr_ctrl c=%0d got wr=%b rd=%b ack=%b required wr=%b rd=0 ack=%b",
                          c, mem_wr[0], mem_rd[0], d_ack[0], (c == 1), (c == 3));
      end
      if (c == 1) begin
        tests_run++;
        if ({mem_addr[0], mem_wdata[0]} !== {32'h200, 32'hDEAD_BEEF}) begin
          fails++; $display("FAIL wr_bus got addr=%h data=%h required 00000200 deadbeef",
                            mem_addr[0], mem_wdata[0]);
        end
      end
      @(posedge clock); #1;
      if (c == 3) begin d_req[0] = 1'b0; d_we[0] = 1'b0; end
    end
    d_req[0] = 1'b1; d_addr[0] = 32'h200;
    exp_d.push_back(32'hDEAD_BEEF);
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clock);
      if (d_ack[0] === 1'b1) seen = 1'b1;
      @(posedge clock); #1;
      if (seen) d_req[0] = 1'b0;
    end
    tests_run++;
    if (!seen) begin
      fails++; $display("FAIL wr_readback_timeout got no d_ack required one within 10 cycles");
    end
    d_req[0] = 1'b0;
  endtask

  task automatic test_lat3();
    @(posedge clock); #1;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h10;
    exp_d.push_back(mem_val(1, 32'h10));
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      tests_run++;
      if ({mem_rd[1], d_ack[1], stall_mem[1]} !== {(c == 1), (c == 5), (c <= 4)}) begin
        fails++; $display("FAIL lat3 c=%0d got rd=%b ack=%b stall=%b required rd=%b ack=%b stall=%b",
                          c, mem_rd[1], d_ack[1], stall_mem[1], (c == 1), (c == 5), (c <= 4));
      end
      if (c == 1) begin
        tests_run++;
        if (mem_addr[1] !== 32'h10) begin
          fails++; $display("FAIL lat3_addr got %h required 00000010", mem_addr[1]);
        end
      end
      @(posedge clock); #1;
      if (c == 5) d_req[1] = 1'b0;
    end
  endtask

  task automatic test_reset_wait();
    int acks = 0;
    @(posedge clock); #1;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h14;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1; d_req[1] = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    last_d[0] = 32'h0; last_d[1] = 32'h0;
    @(negedge clock);
    tests_run++;
    if ({mem_rd[1], mem_wr[1], i_ack[1], d_ack[1]} !== 4'b0) begin
      fails++; $display("FAIL rstwait_ctrl got %b required 0000",
                        {mem_rd[1], mem_wr[1], i_ack[1], d_ack[1]});
    end
    tests_run++;
    if ((mem_addr[1] | mem_wdata[1] | d_rdata[1] | i_rdata[1]) !== 32'h0) begin
      fails++; $display("FAIL rstwait_data got addr=%h drd=%h required 0", mem_addr[1], d_rdata[1]);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (d_ack[1] === 1'b1) acks++;
    end
    tests_run++;
    if (acks != 0) begin
      fails++; $display("FAIL rstwait_no_ack got %0d acks required 0", acks);
    end
    @(posedge clock); #1;
    d_req[1] = 1'b1; d_addr[1] = 32'h18;
    exp_d.push_back(mem_val(1, 32'h18));
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      tests_run++;
      if (d_ack[1] !== (c == 5)) begin
        fails++; $display("FAIL rstwait_fresh_ack c=%0d got %b required %b", c, d_ack[1], (c == 5));
      end
      @(posedge clock); #1;
      if (c == 5) d_req[1] = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_starvation();
    test_conflict();
    test_write();
    test_lat3();
    test_reset_wait();
    repeat (2) @(posedge clock);
    tests_run++;
    if ((exp_i.size() + exp_d.size()) != 0) begin
      fails++; $display("FAIL scoreboard_drain got %0d pending required 0", exp_i.size() + exp_d.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/arbitro_memoria.md
# arbitro_memoria

Arbitrates the single-ported shared memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the 5-stage MIPS pipeline. It serialises accesses, sequences the memory's fixed read latency, returns read data with a one-cycle acknowledge pulse, and drives the per-stage stall outputs. Data accesses take priority, and a starvation guard forces a periodic fetch grant.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from the memory strobe to valid `mem_rdata` (legal range 1–7)
- STARVE_MAX, 4, number of consecutive data grants made while `i_req` is pending, after which fetch wins (1–15)

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  system clock, all state updates on its rising edge
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request; held until `i_ack`
- i_addr  in  ADDR_W  fetch address; stable while `i_req`
- i_rdata  out  DATA_W  fetched instruction; valid when `i_ack`, held afterwards
- i_ack  out  1  one-cycle completion pulse to the fetch port
- d_req  in  1  data request; held until `d_ack`
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  load data; valid when `d_ack` after a read, held afterwards
- d_ack  out  1  one-cycle completion pulse to the data port
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rd  out  1  read strobe, exactly one cycle per read
- mem_wr  out  1  write strobe, exactly one cycle per write
- mem_rdata  in  DATA_W  memory read data
- stall_if  out  1  = `i_req & ~i_ack` (combinational)
- stall_mem  out  1  = `d_req & ~d_ack` (combinational)

## Operation
- FSM states: IDLE, STROBE, WAIT, DONE.
- Reset values: state = IDLE; all registered outputs = 0 (`mem_*`, both acks, both rdata registers); `starve_cnt` = 0; `lat_cnt` = 0.
- **IDLE:**
  - No request pending: remain in IDLE.
  - Any request pending: choose the grant, latch the granted port's address, write data and `we`, then go to STROBE.
  - Grant rule: if only one port requests, that port wins. If both request, data wins unless `starve_cnt == STARVE_MAX`, in which case fetch wins.
- **STROBE:** assert `mem_addr`/`mem_wdata` from the latched values. Assert `mem_rd` (fetch, or data read) or `mem_wr` (data write) for this cycle only. Load `lat_cnt = MEM_LAT - 1`, then go to WAIT.
- **WAIT:** `mem_addr` is held and the strobes are low.
  - `lat_cnt != 0`: decrement.
  - `lat_cnt == 0`: for a read, capture `mem_rdata` into the granted port's rdata register; go to DONE.
  - Writes pass through the same WAIT count, so every access has the same latency.
- **DONE:** pulse the granted port's ack for one cycle, then go to IDLE. The non-granted rdata register is untouched. A write leaves `d_rdata` unchanged.
- **starve_cnt:**
  - Increments (saturating at STARVE_MAX) on each data grant made while `i_req` = 1.
  - Clears on any fetch grant.
  - Is unchanged on a data grant made with `i_req` = 0.
- **Requester rule:** `req` and its operands stay stable until ack is seen, and `req` drops (or a new request begins) the cycle after ack. A `req` seen in the IDLE cycle that follows DONE is treated as a new request.
- **Request withdrawn before ack:** the access still completes and the ack still pulses (a write is still performed).
- **Reset mid-access:**
  - The access is abandoned; no ack is issued.
  - `mem_rd`/`mem_wr` are low from the next cycle.
  - A write whose strobe has already been issued stays committed.
- **Simultaneous events:** a new request arriving in STROBE, WAIT or DONE is only considered at the next IDLE.

## Timing
- A request present in IDLE cycle T gives:
  - strobe in cycle T+1
  - data captured at the end of cycle T+1+MEM_LAT
  - ack and valid rdata in cycle T+2+MEM_LAT (T+3 for MEM_LAT=1)
- Throughput: one access per MEM_LAT+3 cycles; there is no overlap between accesses.
- `stall_if`/`stall_mem` are combinational from `req` and ack, with zero added delay.

## Test plan
- **Lone fetch (MEM_LAT=1):** `i_req` at T, `i_addr=0x40`, memory returns `0x8C010004` → `mem_rd` = 1 only at T+1 with `mem_addr=0x40`; `i_ack` = 1 only at T+3 with `i_rdata=0x8C010004`; `stall_if` = 1 for T..T+2.
- **Conflict:** `i_req` and `d_req` (read, `0x100`) both raised at T → data served first (`d_ack` at T+3); fetch strobe at T+5, `i_ack` at T+7; `stall_if` held through T+6.
- **Starvation guard:** `i_req` held high while data issues 5 back-to-back reads (STARVE_MAX=4) → 4 data acks, then a fetch grant, then the 5th data access; `starve_cnt` returns to 0.
- **Write:** `d_we`=1, `d_addr=0x200`, `d_wdata=0xDEADBEEF` → a single `mem_wr` cycle with those values; `d_ack` at T+3; `d_rdata` unchanged.
- **MEM_LAT=3:** read `0x10` → strobe at T+1, capture at end of T+4, `d_ack` at T+5.
- **Reset in WAIT:** assert reset during WAIT (MEM_LAT=3) → no ack; state IDLE; all outputs 0 next cycle; a fresh request then completes normally.
